// File: rtl/sha256_id_issuer.sv
// Round-robin message-ID issuer for the SHA-256 engine ID buffer, throttled by an outstanding-ID count.
// Optional retire-order checker: define SHA256_ID_ISSUER_ORDER_CHECK_EN.
//
// state  | meaning
// S_IDLE | no output pending
// S_PUSH | id_out_valid high, waiting on id_out_ready
// S_FULL | outstanding == MAX_OUT, no issue until a retire
module sha256_id_issuer #(
  parameter int NUM_REQ = 2,
  parameter int MAX_OUT = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic               sync_rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_last,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [5:0]         req_id,
  output logic [5:0]         id_out,
  output logic               id_out_last,
  output logic               id_out_valid,
  input  logic               id_out_ready,
  input  logic               done_valid,
  input  logic [5:0]         done_id,
  output logic [3:0]         outstanding,
  output logic               err_order
);

  localparam int              PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0]      MAX_CNT = 4'(MAX_OUT);
  localparam logic [PW-1:0]   PTR_RST = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_PUSH, S_FULL} state_t;

  state_t        state_q, state_d;
  logic [5:0]    next_id_q, next_id_d;
  logic [5:0]    id_q, id_d;
  logic          last_q, last_d;
  logic [3:0]    out_cnt_q, out_cnt_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0]   rot_valid;
  logic [PW:0]          rot_sh;
  logic [PW-1:0]        win_idx;
  logic                 win_found;
  logic                 issue;
  logic                 done_eff;
  logic [NUM_REQ-1:0]   grant;

  // Rotate requests so bit 0 is the requester just after the last grant.
  assign dbl_valid = {req_valid, req_valid};
  assign rot_sh    = {1'b0, rr_ptr_q} + (PW+1)'(1);
  assign rot_valid = NUM_REQ'(dbl_valid >> rot_sh);

  always_comb begin
    int t;
    t         = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && rot_valid[k]) begin
        win_found = 1'b1;
        t = int'(rr_ptr_q) + 1 + k;
        if (t >= NUM_REQ) t = t - NUM_REQ;
        win_idx = PW'(t);
      end
    end
  end

  assign issue = en && !sync_rst && win_found && (out_cnt_q < MAX_CNT) &&
                 ((state_q == S_IDLE) || ((state_q == S_PUSH) && id_out_ready));
  assign done_eff = en && done_valid && (out_cnt_q != 4'd0);
  assign grant    = issue ? (NUM_REQ'(1) << win_idx) : '0;

  always_comb begin
    state_d   = state_q;
    next_id_d = next_id_q;
    id_d      = id_q;
    last_d    = last_q;
    out_cnt_d = out_cnt_q;
    rr_ptr_d  = rr_ptr_q;

    if (issue) begin
      id_d      = next_id_q;
      last_d    = |(req_last & grant);
      next_id_d = next_id_q + 6'd1;
      rr_ptr_d  = win_idx;
    end

    case ({issue, done_eff})
      2'b10:   out_cnt_d = out_cnt_q + 4'd1;
      2'b01:   out_cnt_d = out_cnt_q - 4'd1;
      default: out_cnt_d = out_cnt_q;
    endcase

    case (state_q)
      S_IDLE: if (issue) state_d = S_PUSH;
      S_PUSH: begin
        if (en && id_out_ready && !issue)
          state_d = (out_cnt_d == MAX_CNT) ? S_FULL : S_IDLE;
      end
      S_FULL: if (done_eff) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q   <= S_IDLE;
      next_id_q <= '0;
      id_q      <= '0;
      last_q    <= 1'b0;
      out_cnt_q <= '0;
      rr_ptr_q  <= PTR_RST;
    end else if (sync_rst) begin
      state_q   <= S_IDLE;
      next_id_q <= '0;
      id_q      <= '0;
      last_q    <= 1'b0;
      out_cnt_q <= '0;
      rr_ptr_q  <= PTR_RST;
    end else begin
      state_q   <= state_d;
      next_id_q <= next_id_d;
      id_q      <= id_d;
      last_q    <= last_d;
      out_cnt_q <= out_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign req_ready    = grant;
  assign req_id       = issue ? next_id_q : 6'd0;
  assign id_out       = id_q;
  assign id_out_last  = last_q;
  assign id_out_valid = (state_q == S_PUSH);
  assign outstanding  = out_cnt_q;

`ifdef SHA256_ID_ISSUER_ORDER_CHECK_EN
  logic [5:0] expect_q;
  logic       err_q;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      expect_q <= '0;
      err_q    <= 1'b0;
    end else if (sync_rst) begin
      expect_q <= '0;
      err_q    <= 1'b0;
    end else if (en && done_valid) begin
      expect_q <= expect_q + 6'd1;
      if (done_id != expect_q) err_q <= 1'b1;
    end
  end

  assign err_order = err_q;
`else
  logic unused_done_id;
  assign unused_done_id = ^done_id;
  assign err_order      = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_id_issuer.sv
// Directed bench for sha256_id_issuer (NUM_REQ=2, MAX_OUT=8); expected values are hand-derived.
module tb_sha256_id_issuer;

  logic       clk = 1'b0;
  logic       nrst, en, sync_rst;
  logic [1:0] req_valid, req_last, req_ready;
  logic [5:0] req_id, id_out, done_id;
  logic       id_out_last, id_out_valid, id_out_ready, done_valid;
  logic [3:0] outstanding;
  logic       err_order;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SHA256_ID_ISSUER_ORDER_CHECK_EN
  localparam bit ORDER_EN = 1'b1;
`else
  localparam bit ORDER_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  sha256_id_issuer #(.NUM_REQ(2), .MAX_OUT(8)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .sync_rst     (sync_rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .req_id       (req_id),
    .id_out       (id_out),
    .id_out_last  (id_out_last),
    .id_out_valid (id_out_valid),
    .id_out_ready (id_out_ready),
    .done_valid   (done_valid),
    .done_id      (done_id),
    .outstanding  (outstanding),
    .err_order    (err_order)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sync_rst();
    sync_rst   = 1'b1;
    req_valid  = 2'b00;
    req_last   = 2'b00;
    done_valid = 1'b0;
    step();
    sync_rst = 1'b0;
  endtask

  initial begin
    int  n_grant;
    bit  prev_hold;
    logic [5:0] prev_id;

    nrst = 1'b1; en = 1'b1; sync_rst = 1'b0;
    req_valid = 2'b00; req_last = 2'b00; id_out_ready = 1'b0;
    done_valid = 1'b0; done_id = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_id_out", id_out, 0);
    check("rst_last", id_out_last, 0);
    check("rst_valid", id_out_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_req_id", req_id, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err_order, 0);
    nrst = 1'b0;
    step();

    // single request
    req_valid = 2'b01; req_last = 2'b01; id_out_ready = 1'b1;
    #2;
    check("t1_grant", req_ready, 2'b01);
    check("t1_id", req_id, 0);
    step();
    req_valid = 2'b00; req_last = 2'b00;
    #2;
    check("t1_valid", id_out_valid, 1);
    check("t1_id_out", id_out, 0);
    check("t1_last", id_out_last, 1);
    check("t1_outstanding", outstanding, 1);
    check("t1_no_grant", req_ready, 0);
    step();
    #2;
    check("t1_idle", id_out_valid, 0);

    // global enable
    do_sync_rst();
    en = 1'b0; req_valid = 2'b01;
    #2;
    check("en_no_grant", req_ready, 0);
    step();
    #2;
    check("en_outstanding", outstanding, 0);
    check("en_valid", id_out_valid, 0);
    en = 1'b1;
    #2;
    check("en_grant", req_ready, 2'b01);
    check("en_id", req_id, 0);
    step();
    req_valid = 2'b00; en = 1'b0;
    #2;
    check("en_push_valid", id_out_valid, 1);
    step();
    #2;
    check("en_push_hold", id_out_valid, 1);
    en = 1'b1;
    step();
    #2;
    check("en_push_done", id_out_valid, 0);

    // round-robin
    do_sync_rst();
    req_valid = 2'b11; id_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("rr_grant", req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
      check("rr_id", req_id, i);
      step();
    end
    req_valid = 2'b00;
    #2;
    check("rr_outstanding", outstanding, 4);
    step();

    // fill to MAX_OUT under toggling back-pressure
    do_sync_rst();
    req_valid = 2'b01;
    n_grant = 0; prev_hold = 1'b0; prev_id = 6'd0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      id_out_ready = (cyc % 2 == 1);
      #2;
      if (prev_hold) check("bp_stable", id_out, prev_id);
      if (req_ready != 2'b00) begin
        check("bp_id", req_id, n_grant);
        n_grant++;
      end
      prev_hold = id_out_valid && !id_out_ready;
      prev_id   = id_out;
      step();
    end
    #2;
    check("bp_count", n_grant, 8);
    check("bp_outstanding", outstanding, 8);
    check("bp_full_no_grant", req_ready, 0);
    check("bp_full_valid", id_out_valid, 0);
    done_valid = 1'b1; done_id = 6'd0;
    #2;
    check("full_done_no_grant", req_ready, 0);
    step();
    done_valid = 1'b0;
    #2;
    check("full_exit_grant", req_ready, 2'b01);
    check("full_exit_id", req_id, 8);
    check("full_exit_outstanding", outstanding, 7);
    step();
    req_valid = 2'b00;
    #2;
    check("full_reissue_out", outstanding, 8);
    check("full_reissue_id_out", id_out, 8);
    check("full_reissue_valid", id_out_valid, 1);
    step();

    // wrap with same-cycle retire
    do_sync_rst();
    id_out_ready = 1'b1; req_valid = 2'b01;
    #2;
    check("wrap_first_id", req_id, 0);
    step();
    for (int i = 1; i <= 64; i++) begin
      done_valid = 1'b1; done_id = 6'(i - 1);
      #2;
      check("wrap_id", req_id, i % 64);
      check("wrap_out", outstanding, 1);
      step();
    end
    done_valid = 1'b0; req_valid = 2'b00;
    #2;
    check("wrap_id_out", id_out, 0);
    check("wrap_outstanding", outstanding, 1);
    check("wrap_err", err_order, 0);
    step();

    // retire-order checker
    do_sync_rst();
    done_valid = 1'b1; done_id = 6'd0;
    step();
    done_id = 6'd2;
    #2;
    check("ord_before", err_order, 0);
    step();
    done_valid = 1'b0;
    #2;
    check("ord_set", err_order, 32'(ORDER_EN));
    step();
    step();
    #2;
    check("ord_sticky", err_order, 32'(ORDER_EN));
    sync_rst = 1'b1;
    step();
    sync_rst = 1'b0;
    #2;
    check("ord_cleared", err_order, 0);

    // sync reset during a stalled push
    do_sync_rst();
    req_valid = 2'b01; id_out_ready = 1'b0;
    step();
    id_out_ready = 1'b1;
    step();
    req_valid = 2'b00; id_out_ready = 1'b0;
    #2;
    check("mid_valid", id_out_valid, 1);
    check("mid_id_out", id_out, 1);
    check("mid_outstanding", outstanding, 2);
    sync_rst = 1'b1;
    step();
    sync_rst = 1'b0;
    #2;
    check("mid_rst_valid", id_out_valid, 0);
    check("mid_rst_out", outstanding, 0);
    req_valid = 2'b01;
    #2;
    check("mid_rst_grant", req_ready, 2'b01);
    check("mid_rst_id", req_id, 0);
    step();
    req_valid = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
